// File: rtl/uart_loader_pkg.sv
// Shared types for the serial boot loader: receiver/loader state encodings, byte lanes, imem write bus.
// No logic of its own; word_addr turns a word index into a zero-extended byte address.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_SYNC,
    L_LEN0,
    L_LEN1,
    L_DATA
  } ld_state_t;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } imem_req_t;

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchronizer; byte_vld ~9.5 bit-times after the start edge.
// No backpressure: byte_vld/frame_err are single-cycle pulses and must be consumed when seen.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_bit,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            vld_q, vld_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_bit;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    vld_d     = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d   = RX_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      RX_START: begin
        // Mid-bit resample rejects short low glitches without flagging an error.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) vld_d = 1'b1;
          else      ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_vld  = vld_q;
  assign byte_dat  = shift_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: SYNC, 16-bit LE word count, LE 32-bit words written to imem; holds core while loading.
// imem_wr one cycle after each 4th data byte, load_done the cycle after the last write; no backpressure.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         MAX_WORDS    = 1024,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  output logic        imem_wr,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic       byte_vld;
  logic [7:0] byte_dat;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .rx_bit   (rx_bit),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .frame_err(frame_err)
  );

  ld_state_t   ld_q, ld_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  lane_t       lane_q, lane_d;
  logic [31:0] word_q, word_d;
  imem_req_t   imem_q, imem_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fin_q, fin_d;
  logic [15:0] cnt_new;

  assign cnt_new = {byte_dat, count_q[7:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_q       <= L_SYNC;
      count_q    <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      imem_q     <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      ld_q       <= ld_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      imem_q     <= imem_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fin_q      <= fin_d;
    end
  end

  always_comb begin
    ld_d       = ld_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    word_d     = word_q;
    imem_d     = imem_q;
    imem_d.wr  = 1'b0;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    fin_d      = 1'b0;
    case (ld_q)
      L_SYNC: begin
        if (byte_vld && byte_dat == SYNC_BYTE) begin
          ld_d       = L_LEN0;
          hold_d     = 1'b1;
          err_d      = 1'b0;
          word_cnt_d = '0;
          lane_d     = '0;
        end
      end
      L_LEN0: begin
        if (frame_err) begin
          err_d = 1'b1;
          ld_d  = L_SYNC;
        end else if (byte_vld) begin
          count_d = {count_q[15:8], byte_dat};
          ld_d    = L_LEN1;
        end
      end
      L_LEN1: begin
        if (frame_err) begin
          err_d = 1'b1;
          ld_d  = L_SYNC;
        end else if (byte_vld) begin
          count_d = cnt_new;
          if (cnt_new == 16'd0) begin
            done_d = 1'b1;
            hold_d = 1'b0;
            ld_d   = L_SYNC;
          end else if ({1'b0, cnt_new} > MAX_W) begin
            // Oversized image: refuse it but keep the core parked.
            err_d = 1'b1;
            ld_d  = L_SYNC;
          end else begin
            ld_d = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (fin_q) begin
          done_d = 1'b1;
          hold_d = 1'b0;
          ld_d   = L_SYNC;
        end else if (frame_err) begin
          err_d = 1'b1;
          ld_d  = L_SYNC;
        end else if (byte_vld) begin
          if (lane_q == 2'd3) begin
            imem_d.wr    = 1'b1;
            imem_d.addr  = word_addr(word_cnt_q);
            imem_d.wdata = {byte_dat, word_q[23:0]};
            word_cnt_d   = word_cnt_q + 16'd1;
            lane_d       = '0;
            fin_d        = (word_cnt_q + 16'd1 == count_q);
          end else begin
            word_d[{lane_q, 3'b000} +: 8] = byte_dat;
            lane_d                        = lane_q + 2'd1;
          end
        end
      end
      default: ld_d = L_SYNC;
    endcase
  end

  assign imem_wr    = imem_q.wr;
  assign imem_addr  = imem_q.addr;
  assign imem_wdata = imem_q.wdata;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial frames in, expected imem writes queued and compared on each imem_wr.
module tb_uart_boot_loader;

  localparam int CPB = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_bit = 1'b1;
  logic        imem_wr;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  wr_t wq[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  int  byte_cnt = 0;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (1024),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_bit    (rx_bit),
    .imem_wr   (imem_wr),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_bit = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      wait_clks(CPB);
    end
    rx_bit = stop;
    wait_clks(CPB);
    rx_bit = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send_all(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (dut.byte_vld) byte_cnt++;
      if (load_done) done_cnt++;
      if (imem_wr) begin
        wr_t e;
        wr_cnt++;
        chk("wr_excl_done", {63'd0, load_done}, 64'd0);
        chk("wr_expected", {63'd0, wq.size() != 0}, 64'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", {32'd0, imem_addr}, {32'd0, e.addr});
          chk("wr_data", {32'd0, imem_wdata}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    bq_t f;
    int  d0, w0, b0;

    // Reset and idle line.
    wait_clks(5);
    reset = 1'b1;
    wait_clks(100);
    @(negedge clock);
    chk("rst_wr", {63'd0, imem_wr}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("rst_hold", {63'd0, core_hold}, 64'd0);
    chk("rst_done", {63'd0, load_done}, 64'd0);
    chk("rst_err", {63'd0, load_err}, 64'd0);
    chk("rst_nowr", 64'(wr_cnt), 64'd0);

    // Two-word image.
    d0 = done_cnt;
    push_wr(32'h0, 32'h1234_5678);
    push_wr(32'h4, 32'hDEAD_BEEF);
    send_byte(8'hA5, 1'b1);
    @(negedge clock);
    chk("f1_hold_after_sync", {63'd0, core_hold}, 64'd1);
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_all(f);
    @(negedge clock);
    chk("f1_done", 64'(done_cnt - d0), 64'd1);
    chk("f1_hold", {63'd0, core_hold}, 64'd0);
    chk("f1_err", {63'd0, load_err}, 64'd0);
    chk("f1_drained", 64'(wq.size()), 64'd0);

    // Junk byte then zero-length image.
    d0 = done_cnt;
    w0 = wr_cnt;
    f = '{8'h3C, 8'hA5, 8'h00, 8'h00};
    send_all(f);
    @(negedge clock);
    chk("f2_done", 64'(done_cnt - d0), 64'd1);
    chk("f2_nowr", 64'(wr_cnt - w0), 64'd0);
    chk("f2_hold", {63'd0, core_hold}, 64'd0);

    // Framing error mid-image.
    w0 = wr_cnt;
    d0 = done_cnt;
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_all(f);
    send_byte(8'h33, 1'b0);
    wait_clks(2 * CPB);
    @(negedge clock);
    chk("f3_err", {63'd0, load_err}, 64'd1);
    chk("f3_hold", {63'd0, core_hold}, 64'd1);
    chk("f3_nowr", 64'(wr_cnt - w0), 64'd0);
    chk("f3_nodone", 64'(done_cnt - d0), 64'd0);

    // Recovery load clears the error.
    d0 = done_cnt;
    push_wr(32'h0, 32'hCAFE_F00D);
    f = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_all(f);
    @(negedge clock);
    chk("f4_done", 64'(done_cnt - d0), 64'd1);
    chk("f4_err", {63'd0, load_err}, 64'd0);
    chk("f4_hold", {63'd0, core_hold}, 64'd0);

    // Oversized count (1025 words).
    w0 = wr_cnt;
    f = '{8'hA5, 8'h01, 8'h04};
    send_all(f);
    @(negedge clock);
    chk("f5_err", {63'd0, load_err}, 64'd1);
    chk("f5_hold", {63'd0, core_hold}, 64'd1);
    d0 = done_cnt;
    f = '{8'hA5, 8'h00, 8'h00};
    send_all(f);
    @(negedge clock);
    chk("f5_back_in_sync", 64'(done_cnt - d0), 64'd1);
    chk("f5_nowr", 64'(wr_cnt - w0), 64'd0);

    // Short low glitch on an idle line.
    b0 = byte_cnt;
    rx_bit = 1'b0;
    wait_clks(4);
    rx_bit = 1'b1;
    wait_clks(3 * CPB);
    @(negedge clock);
    chk("glitch_nobyte", 64'(byte_cnt - b0), 64'd0);
    chk("glitch_hold", {63'd0, core_hold}, 64'd0);

    // Reset in the middle of the data phase.
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
    send_all(f);
    rx_bit = 1'b0;
    wait_clks(40);
    reset = 1'b0;
    wait_clks(3);
    @(negedge clock);
    chk("mid_rst_hold", {63'd0, core_hold}, 64'd0);
    chk("mid_rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("mid_rst_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("mid_rst_err", {63'd0, load_err}, 64'd0);
    rx_bit = 1'b1;
    wait_clks(5);
    reset = 1'b1;
    wait_clks(50);
    d0 = done_cnt;
    push_wr(32'h0, 32'hDEAD_BEEF);
    f = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_all(f);
    @(negedge clock);
    chk("f6_done", 64'(done_cnt - d0), 64'd1);
    chk("f6_hold", {63'd0, core_hold}, 64'd0);
    chk("f6_err", {63'd0, load_err}, 64'd0);

    chk("all_drained", 64'(wq.size()), 64'd0);
    chk("total_writes", 64'(wr_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
